// File: rtl/gelu_lut_loader_if.sv
// Stream/lookup bundle for gelu_lut_loader: table-load stream in, lookup request in, registered result out.
// GELU_LUT_CSUM_EN adds the load_err status line.
interface gelu_lut_loader_if #(
  parameter int DATA_W = 8
);
  logic              load_start;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              load_done;
  logic              in_valid;
  logic [DATA_W-1:0] x_in;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] y_out;
`ifdef GELU_LUT_CSUM_EN
  logic              load_err;
`endif

  modport master (
    output load_start, wr_valid, wr_data, in_valid, x_in,
`ifdef GELU_LUT_CSUM_EN
    input  load_err,
`endif
    input  wr_ready, load_done, in_ready, out_valid, y_out
  );

  modport slave (
    input  load_start, wr_valid, wr_data, in_valid, x_in,
`ifdef GELU_LUT_CSUM_EN
    output load_err,
`endif
    output wr_ready, load_done, in_ready, out_valid, y_out
  );
endinterface

// File: rtl/gelu_lut_loader.sv
// Programmable 2**DATA_W-entry activation table: streamed load, then one-cycle registered lookups.
// Optional GELU_LUT_CSUM_EN: a leading checksum word is verified against the mod-256 sum of entries.
module gelu_lut_loader #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  gelu_lut_loader_if.slave  bus
);
  localparam int DEPTH  = 2 ** DATA_W;
  localparam int ADDR_W = DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_table [DEPTH];
  logic              r_out_valid;
  logic [DATA_W-1:0] r_y_out;

  logic              w_start;
  logic              w_wr_fire;
  logic              w_tbl_we;
  logic              w_last;
  logic              w_rd_fire;
  logic              w_fail;
  logic [ADDR_W-1:0] w_rd_idx;

  // load_start only matters outside LOAD; a running load cannot be restarted
  assign w_start   = bus.load_start && (r_state != S_LOAD);
  assign w_wr_fire = (r_state == S_LOAD) && bus.wr_valid;
  assign w_last    = (r_addr == ADDR_W'(DEPTH - 1));
  assign w_rd_fire = bus.in_valid && (r_state == S_READY);
  // Offset-binary index: flipping the sign bit adds 2**(DATA_W-1)
  assign w_rd_idx  = {~bus.x_in[DATA_W-1], bus.x_in[DATA_W-2:0]};

`ifdef GELU_LUT_CSUM_EN
  logic              r_csum_pend;
  logic [DATA_W-1:0] r_csum_exp;
  logic [DATA_W-1:0] r_csum_sum;
  logic              r_load_err;
  logic [DATA_W-1:0] w_sum_next;

  assign w_sum_next = r_csum_sum + bus.wr_data;
  assign w_tbl_we   = w_wr_fire && !r_csum_pend;
  assign w_fail     = (w_sum_next != r_csum_exp);
  assign bus.load_err = r_load_err;

  // First transfer of a load is the expected checksum, not a table entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_csum_pend <= 1'b0;
      r_csum_exp  <= '0;
      r_csum_sum  <= '0;
      r_load_err  <= 1'b0;
    end else if (w_start) begin
      r_csum_pend <= 1'b1;
      r_csum_sum  <= '0;
      r_load_err  <= 1'b0;
    end else if (w_wr_fire) begin
      if (r_csum_pend) begin
        r_csum_exp  <= bus.wr_data;
        r_csum_pend <= 1'b0;
      end else begin
        r_csum_sum <= w_sum_next;
        if (w_last && w_fail) r_load_err <= 1'b1;
      end
    end
  end
`else
  assign w_tbl_we = w_wr_fire;
  assign w_fail   = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.load_start) w_state_next = S_LOAD;
      S_LOAD:  if (w_tbl_we && w_last) w_state_next = w_fail ? S_IDLE : S_READY;
      S_READY: if (bus.load_start) w_state_next = S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_out_valid <= 1'b0;
      r_y_out     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start)       r_addr <= '0;
      else if (w_tbl_we) r_addr <= r_addr + 1'b1;
      r_out_valid <= w_rd_fire;
      if (w_rd_fire) r_y_out <= r_table[w_rd_idx];
    end
  end

  // Table storage carries no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (w_tbl_we) r_table[r_addr] <= bus.wr_data;
  end

  assign bus.wr_ready  = (r_state == S_LOAD);
  assign bus.in_ready  = (r_state == S_READY);
  assign bus.load_done = (r_state == S_READY);
  assign bus.out_valid = r_out_valid;
  assign bus.y_out     = r_y_out;
endmodule

// File: tb/tb_gelu_lut_loader.sv
// Directed bench for gelu_lut_loader: table loads, lookups, stalls, reset mid-load.
// Compile with GELU_LUT_CSUM_EN defined to also exercise the checksum path.
module tb_gelu_lut_loader;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] tbl [256];

  gelu_lut_loader_if #(.DATA_W(8)) bus ();

  gelu_lut_loader #(.DATA_W(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; request is captured on the next posedge, result seen at the following negedge
  task automatic lookup(input logic [7:0] x, input logic [7:0] exp);
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    check("in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("out_valid", bus.out_valid, 1);
    check("y_out", bus.y_out, exp);
    $display("lookup x=%0d y=%0d exp=%0d", $signed(x), $signed(bus.y_out), $signed(exp));
  endtask

  task automatic do_load(input bit toggle, input bit mid_start, input int abort_at, input bit bad_csum);
    int n;
    int k;
    int cyc;
    int off;
    logic [7:0] sum;
`ifdef GELU_LUT_CSUM_EN
    off = 1;
`else
    off = 0;
`endif
    n   = 256 + off;
    k   = 0;
    cyc = 0;
    sum = 8'h00;
    for (int i = 0; i < 256; i++) sum = sum + tbl[i];
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    while (k < n && cyc < 4000) begin
      if (k == abort_at) begin
        bus.wr_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_load_done", bus.load_done, 0);
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
`ifdef GELU_LUT_CSUM_EN
        check("rst_load_err", bus.load_err, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_load_done", bus.load_done, 0);
        return;
      end
      bus.wr_valid   = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.wr_data    = (off == 1 && k == 0) ? (sum ^ {7'b0, bad_csum}) : tbl[k - off];
      bus.load_start = mid_start && (cyc == 101);
      if (k == 10) check("load_in_ready", bus.in_ready, 0);
      if (k == n - 1) check("done_before_last", bus.load_done, 0);
      if (bus.wr_valid && bus.wr_ready) k++;
      cyc++;
      @(negedge clk);
    end
    bus.wr_valid   = 1'b0;
    bus.load_start = 1'b0;
    check("load_xfers", k, n);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.load_start = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = 8'h00;
    bus.in_valid   = 1'b0;
    bus.x_in       = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_wr_ready", bus.wr_ready, 0);
    check("reset_load_done", bus.load_done, 0);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_y_out", bus.y_out, 0);
`ifdef GELU_LUT_CSUM_EN
    check("reset_load_err", bus.load_err, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Idle: lookups refused
    bus.in_valid = 1'b1;
    bus.x_in     = 8'h00;
    for (int c = 0; c < 10; c++) begin
      check("idle_in_ready", bus.in_ready, 0);
      check("idle_out_valid", bus.out_valid, 0);
      check("idle_y_out", bus.y_out, 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;

    // Identity table
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i - 128);
    do_load(1'b0, 1'b0, -1, 1'b0);
    check("ident_load_done", bus.load_done, 1);
    check("ident_wr_ready", bus.wr_ready, 0);
    lookup(8'h80, 8'h80);
    lookup(8'h00, 8'h00);
    lookup(8'h7F, 8'h7F);
    lookup(8'hFF, 8'hFF);
    @(negedge clk);
    check("gap_out_valid", bus.out_valid, 0);
    check("hold_y_out", bus.y_out, 8'hFF);

    // GELU-like table, back-to-back lookups
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i * 7 + 3);
    tbl[160] = 8'd27;
    tbl[127] = 8'd0;
    tbl[96]  = 8'hFB;
    do_load(1'b0, 1'b0, -1, 1'b0);
    check("gelu_load_done", bus.load_done, 1);
    lookup(8'd32, 8'd27);
    lookup(8'hFF, 8'd0);
    lookup(8'hE0, 8'hFB);
    lookup(8'h00, 8'h83);

    // Stalled load with ignored mid-load load_start
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i - 128);
    do_load(1'b1, 1'b1, -1, 1'b0);
    check("stall_load_done", bus.load_done, 1);
    lookup(8'h9C, 8'h9C);
    lookup(8'h37, 8'h37);
    lookup(8'h80, 8'h80);

    // Lookup coincident with load_start uses the old table
    bus.in_valid   = 1'b1;
    bus.x_in       = 8'h37;
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.load_start = 1'b0;
    check("restart_out_valid", bus.out_valid, 1);
    check("restart_y_out", bus.y_out, 8'h37);
    check("restart_load_done", bus.load_done, 0);
    check("restart_wr_ready", bus.wr_ready, 1);

    // Reset mid-load, then full reload of 0x55
    for (int i = 0; i < 256; i++) tbl[i] = 8'h55;
    do_load(1'b0, 1'b0, 100, 1'b0);
    do_load(1'b0, 1'b0, -1, 1'b0);
    check("reload_load_done", bus.load_done, 1);
    lookup(8'h80, 8'h55);
    lookup(8'h00, 8'h55);
    lookup(8'h7F, 8'h55);
    lookup(8'hB3, 8'h55);

`ifdef GELU_LUT_CSUM_EN
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i - 128);
    do_load(1'b0, 1'b0, -1, 1'b1);
    check("bad_load_err", bus.load_err, 1);
    check("bad_in_ready", bus.in_ready, 0);
    check("bad_load_done", bus.load_done, 0);
    check("bad_wr_ready", bus.wr_ready, 0);
    do_load(1'b0, 1'b0, -1, 1'b0);
    check("good_load_err", bus.load_err, 0);
    check("good_load_done", bus.load_done, 1);
    lookup(8'h80, 8'h80);
    lookup(8'h7F, 8'h7F);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
